// File: rtl/ibex_register_file_mp.sv
// ibex_register_file_mp: multi-port flop register file with a mult/div write port, pending scoreboard and clear engine.
// Defining IBEX_RF_WR_BYPASS_EN forwards same-cycle accepted write data to matching read ports.
module ibex_register_file_mp #(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter int unsigned          NumRdPorts  = 3,
    parameter logic [DataWidth-1:0] WordZeroVal = '0,
    localparam int unsigned         ADDR_WIDTH  = RV32E ? 4 : 5,
    localparam int unsigned         NUM_WORDS   = 2 ** ADDR_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumRdPorts*5-1:0]         raddr_i,
    output logic [NumRdPorts*DataWidth-1:0] rdata_o,
    input  logic                            we_a_i,
    input  logic [4:0]                      waddr_a_i,
    input  logic [DataWidth-1:0]            wdata_a_i,
    input  logic                            we_b_i,
    input  logic [4:0]                      waddr_b_i,
    input  logic [DataWidth-1:0]            wdata_b_i,
    input  logic                            pend_set_i,
    input  logic [4:0]                      pend_addr_i,
    output logic [NUM_WORDS-1:0]            pend_o,
    input  logic                            clr_req_i,
    output logic                            clr_busy_o,
    output logic                            err_o
);
    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                state_q;
    logic [DataWidth-1:0]  rf_q [NUM_WORDS];
    logic [NUM_WORDS-1:0]  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  err_q, err_d, acc_a, acc_b, clr_go;

    // x0 and the upper half of the space in RV32E are never stored
    function automatic logic legal(input logic [4:0] a);
        return (a != 5'd0) && !(RV32E && a[4]);
    endfunction

    assign acc_a  = state_q == IDLE && we_a_i && legal(waddr_a_i);
    assign acc_b  = state_q == IDLE && we_b_i && legal(waddr_b_i) && !(acc_a && waddr_a_i == waddr_b_i);
    assign clr_go = state_q == IDLE && clr_req_i;
    assign err_d  = state_q == CLEAR ? (we_a_i || we_b_i) :
                    (we_a_i && RV32E && waddr_a_i[4]) || (we_b_i && RV32E && waddr_b_i[4]) ||
                    (we_a_i && we_b_i && waddr_a_i == waddr_b_i && waddr_a_i != 5'd0);

    // a new pending mark beats a same-cycle mult/div retirement to the same register
    always_comb begin
        pend_d = pend_q;
        if (acc_b) pend_d[waddr_b_i[ADDR_WIDTH-1:0]] = 1'b0;
        if (state_q == IDLE && pend_set_i && legal(pend_addr_i)) pend_d[pend_addr_i[ADDR_WIDTH-1:0]] = 1'b1;
        if (clr_go) pend_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_WORDS; i++) rf_q[i] <= WordZeroVal;
            pend_q  <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            state_q <= IDLE;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
            if (acc_a) rf_q[waddr_a_i[ADDR_WIDTH-1:0]] <= wdata_a_i;
            if (acc_b) rf_q[waddr_b_i[ADDR_WIDTH-1:0]] <= wdata_b_i;
            if (state_q == CLEAR) begin
                rf_q[idx_q] <= WordZeroVal;
                idx_q       <= idx_q + ADDR_WIDTH'(1);
                if (idx_q == ADDR_WIDTH'(NUM_WORDS - 1)) state_q <= IDLE;
            end else if (clr_req_i) begin
                idx_q   <= ADDR_WIDTH'(1);
                state_q <= CLEAR;
            end
        end
    end

    for (genvar k = 0; k < NumRdPorts; k++) begin : g_rd
        logic [4:0]           ra;
        logic [DataWidth-1:0] base;
        assign ra   = raddr_i[5*k +: 5];
        assign base = legal(ra) ? rf_q[ra[ADDR_WIDTH-1:0]] : WordZeroVal;
`ifdef IBEX_RF_WR_BYPASS_EN
        assign rdata_o[DataWidth*k +: DataWidth] = (acc_a && waddr_a_i == ra) ? wdata_a_i :
                                                   (acc_b && waddr_b_i == ra) ? wdata_b_i : base;
`else
        assign rdata_o[DataWidth*k +: DataWidth] = base;
`endif
    end

    assign pend_o     = pend_q;
    assign clr_busy_o = state_q == CLEAR;
    assign err_o      = err_q;
endmodule

// File: tb/tb_ibex_register_file_mp.sv
// tb_ibex_register_file_mp: directed scoreboard bench for ibex_register_file_mp (RV32I and RV32E instances).
module tb_ibex_register_file_mp;
    localparam int RD = 0, PND = 1, BSY = 2, ERR = 3;
`ifdef IBEX_RF_WR_BYPASS_EN
    localparam logic [31:0] BYP = 32'hDEADBEEF;
`else
    localparam logic [31:0] BYP = 32'h0;
`endif

    typedef struct {
        int          cyc;
        bit          d;
        int          sel;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, n_chk = 0, n_pass = 0;

    logic        clk = 1'b0, rst, e_rst;
    logic [14:0] raddr, e_raddr;
    logic [95:0] rdata, e_rdata;
    logic        we_a, we_b, pend_set, clr_req, e_we_a, e_we_b, e_pend_set, e_clr_req;
    logic [4:0]  waddr_a, waddr_b, pend_addr, e_waddr_a, e_waddr_b, e_pend_addr;
    logic [31:0] wdata_a, wdata_b, e_wdata_a, e_wdata_b, pend;
    logic [15:0] e_pend;
    logic        busy, err, e_busy, e_err;

    ibex_register_file_mp #(.RV32E(1'b0)) u_dut (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata),
        .we_a_i(we_a), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a),
        .we_b_i(we_b), .waddr_b_i(waddr_b), .wdata_b_i(wdata_b),
        .pend_set_i(pend_set), .pend_addr_i(pend_addr), .pend_o(pend),
        .clr_req_i(clr_req), .clr_busy_o(busy), .err_o(err)
    );

    ibex_register_file_mp #(.RV32E(1'b1)) u_dut_e (
        .clk_i(clk), .rst_i(e_rst), .raddr_i(e_raddr), .rdata_o(e_rdata),
        .we_a_i(e_we_a), .waddr_a_i(e_waddr_a), .wdata_a_i(e_wdata_a),
        .we_b_i(e_we_b), .waddr_b_i(e_waddr_b), .wdata_b_i(e_wdata_b),
        .pend_set_i(e_pend_set), .pend_addr_i(e_pend_addr), .pend_o(e_pend),
        .clr_req_i(e_clr_req), .clr_busy_o(e_busy), .err_o(e_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input bit d, input int sel, input int idx);
        case (sel)
            RD:      return d ? e_rdata[32*idx +: 32] : rdata[32*idx +: 32];
            PND:     return d ? {16'h0, e_pend} : pend;
            BSY:     return {31'h0, d ? e_busy : busy};
            default: return {31'h0, d ? e_err : err};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.d, e.sel, e.idx);
            n_chk++;
            if (e.cyc != cyc) $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            else if (a !== e.exp) $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, a, e.exp, cyc);
            else n_pass++;
        end
    end

    task automatic chk(input bit d, input int sel, input int idx, input logic [31:0] exp, input string name);
        exp_t e;
        e.cyc = cyc; e.d = d; e.sel = sel; e.idx = idx; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 0; we_b = 0; pend_set = 0; clr_req = 0;
        e_we_a = 0; e_we_b = 0; e_pend_set = 0; e_clr_req = 0;
    endtask

    task automatic wa(input bit d, input logic [4:0] a, input logic [31:0] v);
        if (d) begin e_we_a = 1; e_waddr_a = a; e_wdata_a = v; end
        else begin we_a = 1; waddr_a = a; wdata_a = v; end
    endtask

    task automatic wb(input bit d, input logic [4:0] a, input logic [31:0] v);
        if (d) begin e_we_b = 1; e_waddr_b = a; e_wdata_b = v; end
        else begin we_b = 1; waddr_b = a; wdata_b = v; end
    endtask

    task automatic rd(input bit d, input int p, input logic [4:0] a);
        if (d) e_raddr[5*p +: 5] = a;
        else raddr[5*p +: 5] = a;
    endtask

    initial begin
        rst = 1; e_rst = 1; idle();
        raddr = '0; e_raddr = '0;
        waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0; pend_addr = '0;
        e_waddr_a = '0; e_waddr_b = '0; e_wdata_a = '0; e_wdata_b = '0; e_pend_addr = '0;
        tick(); tick(); rst = 0; e_rst = 0;
        // reset after loading state
        tick(); wa(0, 1, 32'h101); pend_set = 1; pend_addr = 4;
        tick(); idle(); wa(0, 2, 32'h202);
        tick(); idle(); rd(0, 0, 1); rd(0, 1, 2);
        chk(0, RD, 0, 32'h101, "pre_rst_r1"); chk(0, RD, 1, 32'h202, "pre_rst_r2"); chk(0, PND, 0, 32'h10, "pre_rst_pend");
        tick(); rst = 1;
        chk(0, RD, 0, 0, "rst_r1"); chk(0, RD, 1, 0, "rst_r2"); chk(0, PND, 0, 0, "rst_pend");
        chk(0, BSY, 0, 0, "rst_busy"); chk(0, ERR, 0, 0, "rst_err");
        tick(); tick(); rst = 0;
        // basic write and same-cycle read
        tick(); idle(); wa(0, 5, 32'hDEADBEEF); rd(0, 0, 5);
        chk(0, RD, 0, BYP, "same_cycle_r5");
        tick(); idle(); rd(0, 0, 5); rd(0, 1, 5); rd(0, 2, 5);
        for (int p = 0; p < 3; p++) chk(0, RD, p, 32'hDEADBEEF, $sformatf("r5_port%0d", p));
        // collision, x0 write, dual distinct writes
        tick(); idle(); wa(0, 7, 32'h11); wb(0, 7, 32'h22);
        chk(0, ERR, 0, 0, "err_before_coll");
        tick(); idle(); rd(0, 0, 7); wa(0, 0, 32'hFFFF);
        chk(0, RD, 0, 32'h11, "coll_r7"); chk(0, ERR, 0, 1, "coll_err");
        tick(); idle(); rd(0, 0, 0); wa(0, 10, 32'hAA); wb(0, 11, 32'hBB);
        chk(0, RD, 0, 0, "x0_read"); chk(0, ERR, 0, 0, "coll_err_one_cycle");
        tick(); idle(); rd(0, 0, 10); rd(0, 1, 11);
        chk(0, RD, 0, 32'hAA, "dual_r10"); chk(0, RD, 1, 32'hBB, "dual_r11"); chk(0, ERR, 0, 0, "dual_err");
        // pending scoreboard
        tick(); idle(); pend_set = 1; pend_addr = 9;
        tick(); idle(); wa(0, 9, 32'h99);
        chk(0, PND, 0, 32'h200, "pend9_set");
        tick(); idle(); wb(0, 9, 32'hABCD);
        chk(0, PND, 0, 32'h200, "pend9_after_porta");
        tick(); idle(); rd(0, 0, 9); pend_set = 1; pend_addr = 12; wb(0, 12, 32'h1212);
        chk(0, RD, 0, 32'hABCD, "r9_portb"); chk(0, PND, 0, 0, "pend9_cleared");
        tick(); idle(); rd(0, 0, 12);
        chk(0, PND, 0, 32'h1000, "pend12_set_wins"); chk(0, RD, 0, 32'h1212, "r12_portb");
        // clear engine
        for (int r = 1; r < 32; r++) begin tick(); idle(); wa(0, 5'(r), r); end
        tick(); idle(); clr_req = 1;
        chk(0, BSY, 0, 0, "clr_busy_t0");
        tick(); idle(); wa(0, 3, 32'h33);
        chk(0, BSY, 0, 1, "clr_busy_t1"); chk(0, PND, 0, 0, "clr_pend");
        tick(); idle(); clr_req = 1; rd(0, 0, 31); rd(0, 1, 1); rd(0, 2, 3);
        chk(0, BSY, 0, 1, "clr_busy_t2"); chk(0, ERR, 0, 1, "clr_wr_err");
        chk(0, RD, 0, 31, "clr_partial_r31"); chk(0, RD, 1, 0, "clr_partial_r1"); chk(0, RD, 2, 3, "clr_dropped_r3");
        for (int i = 3; i < 32; i++) begin
            tick(); idle();
            chk(0, BSY, 0, 1, $sformatf("clr_busy_t%0d", i));
            if (i == 3) chk(0, ERR, 0, 0, "clr_req_no_err");
        end
        tick(); idle();
        chk(0, BSY, 0, 0, "clr_done");
        for (int r = 1; r < 32; r++) begin
            rd(0, 0, 5'(r)); chk(0, RD, 0, 0, $sformatf("cleared_r%0d", r));
            tick(); idle();
        end
        // RV32E instance
        wa(1, 20, 32'h55); wb(1, 3, 32'h33);
        tick(); idle(); rd(1, 0, 20); rd(1, 1, 3); rd(1, 2, 4);
        chk(1, RD, 0, 0, "e_r20"); chk(1, RD, 1, 32'h33, "e_r3"); chk(1, RD, 2, 0, "e_r4_no_alias"); chk(1, ERR, 0, 1, "e_illegal_err");
        tick(); idle(); e_clr_req = 1;
        chk(1, ERR, 0, 0, "e_err_one_cycle");
        for (int i = 1; i < 16; i++) begin
            tick(); idle();
            chk(1, BSY, 0, 1, $sformatf("e_clr_busy_t%0d", i));
        end
        tick(); idle();
        chk(1, BSY, 0, 0, "e_clr_done"); chk(1, RD, 1, 0, "e_cleared_r3");
        wa(1, 14, 32'hEE);
        tick(); idle(); rd(1, 0, 14); e_clr_req = 1;
        chk(1, RD, 0, 32'hEE, "e_r14");
        tick(); idle();
        chk(1, BSY, 0, 1, "e_mid_busy1");
        tick(); idle();
        chk(1, BSY, 0, 1, "e_mid_busy2");
        tick(); e_rst = 1;
        chk(1, BSY, 0, 0, "e_rst_busy"); chk(1, RD, 0, 0, "e_rst_r14"); chk(1, ERR, 0, 0, "e_rst_err"); chk(1, PND, 0, 0, "e_rst_pend");
        tick(); tick(); e_rst = 0;
        for (int r = 1; r < 16; r++) begin
            tick(); idle(); rd(1, 0, 5'(r));
            chk(1, RD, 0, 0, $sformatf("e_post_rst_r%0d", r)); chk(1, BSY, 0, 0, $sformatf("e_post_rst_busy%0d", r));
        end
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            $display("FAIL unchecked: %0d entries left, required 0", sb.size());
            n_chk += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ibex_register_file_mp.md
Name: ibex_register_file_mp

Overview:
Multi-port integer register file for the ibex core with mult/div, the next generation of the single-write flop-based RF.
- Generalised read-port count.
- Second write port for long-latency mult/div results.
- Per-register pending scoreboard.
- Sequential hardware clear engine.
Sits between ID (reads, issue-time pending marks) and WB/mult-div (writes).

Parameters:
RV32E, 0, 1 = 16 architectural registers (ADDR_WIDTH 4), else 32 (NUM_WORDS = 2**ADDR_WIDTH).
DataWidth, 32, register word width.
NumRdPorts, 3, number of combinational read ports, legal range 1..4.
WordZeroVal, 0, reset/clear value and x0 read value.

Ports:
clk_i  in  1  clock, all state on rising edge.
rst_i  in  1  reset, asynchronous, active-high.
raddr_i  in  NumRdPorts*5  read addresses, port k at bits [5k+4:5k].
rdata_o  out  NumRdPorts*DataWidth  read data, port k at bits [DataWidth*k +: DataWidth].
we_a_i  in  1  write enable, port A (WB, priority port).
waddr_a_i  in  5  port A address.
wdata_a_i  in  DataWidth  port A data.
we_b_i  in  1  write enable, port B (mult/div).
waddr_b_i  in  5  port B address.
wdata_b_i  in  DataWidth  port B data.
pend_set_i  in  1  mark destination of an issued mult/div op pending.
pend_addr_i  in  5  register to mark.
pend_o  out  NUM_WORDS  pending bitmap, bit i = register i awaiting port-B write.
clr_req_i  in  1  request full RF clear.
clr_busy_o  out  1  clear engine active.
err_o  out  1  registered one-cycle error pulse.

Behaviour:
- Reset (async, rst_i=1): registers 1..NUM_WORDS-1 = WordZeroVal, pend_o=0, clr_busy_o=0, err_o=0, FSM=IDLE.
- Reads: combinational from flop contents, zero latency.
  - x0 always reads WordZeroVal.
  - RV32E: address bit4=1 reads WordZeroVal.
- Writes: take effect at the next rising edge; visible on reads the cycle after.
  - Writes to x0 are dropped silently.
  - RV32E: a write with address bit4=1 is dropped and sets err_o next cycle.
- Collision: we_a_i and we_b_i to the same nonzero address → port A data stored, port B dropped, err_o=1 next cycle. Different addresses → both written.
- Pending scoreboard:
  - pend_set_i sets pend_o[pend_addr_i] at the edge.
  - A port-B write to address n clears pend_o[n]; a port-A write does not clear it.
  - Set and port-B clear to the same address in the same cycle → set wins.
  - pend_addr_i=0 is ignored; pend_o[0] is always 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE + clr_req_i → CLEAR: idx=1, pend_o cleared at the entry edge, clr_busy_o=1 from the next cycle.
  - In CLEAR, each cycle writes WordZeroVal to reg[idx] and increments idx. At idx=NUM_WORDS-1, write then return to IDLE.
  - Busy duration: NUM_WORDS-1 cycles (31, or 15 for RV32E).
  - In CLEAR, any we_a_i or we_b_i is dropped and pulses err_o next cycle.
  - In CLEAR, pend_set_i and clr_req_i are ignored.
  - Reads in CLEAR return current contents (partially cleared).
  - Reset mid-clear → IDLE with all state at reset values.
- err_o: OR of all error causes in a cycle, registered; high exactly one cycle per offending cycle.

Optional Feature:
IBEX_RF_WR_BYPASS_EN
- Defined: a read whose address matches an accepted (non-dropped) write in the same cycle returns that write data. If both ports match, port A data is returned. No bypass for x0, RV32E-illegal addresses, or during CLEAR.
- Undefined: reads return pre-edge flop contents; no write-to-read path.

Test Plan:
1. Assert rst_i for 2 cycles after loading regs → all rdata_o=0, pend_o=0, clr_busy_o=0, err_o=0.
2. we_a_i, addr 5, data 0xDEADBEEF with raddr port0=5 → same cycle reads 0x0 (bypass off) or 0xDEADBEEF (IBEX_RF_WR_BYPASS_EN); next cycle reads 0xDEADBEEF on all ports.
3. Same cycle: port A addr 7 data 0x11, port B addr 7 data 0x22 → reg7=0x11, err_o=1 for exactly one cycle. Write addr 0 data 0xFFFF → x0 still reads 0, err_o=0.
4. pend_set_i addr 9 → pend_o[9]=1.
   - Port-A write to 9 → stays 1.
   - Port-B write 0xABCD to 9 → pend_o[9]=0, reg9=0xABCD.
   - pend_set and port-B write to 12 in the same cycle → pend_o[12]=1.
5. Load regs 1..31 with their index, pulse clr_req_i → clr_busy_o high 31 cycles, all regs 0 afterwards. A we_a_i during CLEAR → dropped, err_o pulse. clr_req_i during CLEAR → no restart.
6. RV32E=1: write addr 20 → dropped, err_o pulse, read addr 20 = 0; clear lasts 15 cycles. Also assert rst_i mid-clear → clr_busy_o=0 immediately, all regs 0.
